// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment encodings are active-low, bit 6 = CA down to bit 0 = CG.
package ssd_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    // Indexed by nibble value; entry 0 sits in the low slot.
    localparam logic [15:0][6:0] SEG_TABLE = {
        SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
        7'b0000100, 7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100,
        7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
    };

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ssd_seg_decode.sv
// Combinational BCD to active-low seven-segment decoder; 10..15 decode to blank.
module ssd_seg_decode
    import ssd_pkg::*;
(
    input  logic [3:0] bcd,
    output seg_t       seg
);

    assign seg = SEG_TABLE[bcd];

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment bank with
// frame-synchronous double buffering. Define SSD_LZB_EN for leading-zero blanking.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              C,
    output logic                    frame_done
);

    localparam int IW = idx_width(NUM_DIGITS);
    localparam int DW = idx_width(REFRESH_DIV);

    logic [DW-1:0]                 div_cnt;
    logic [IW-1:0]                 idx;
    logic [NUM_DIGITS-1:0][3:0]    active;
    logic [NUM_DIGITS-1:0][3:0]    pending;
    logic                          pend_flag;
    logic                          tick;
    logic                          wrap;
    logic [NUM_DIGITS-1:0]         lz_blank;
    seg_t                          cur_seg;
    seg_t                          seg_next;

    assign tick = (div_cnt == DW'(REFRESH_DIV - 1));
    assign wrap = tick && (idx == IW'(NUM_DIGITS - 1));

    ssd_seg_decode u_dec (
        .bcd (active[idx]),
        .seg (cur_seg)
    );

`ifdef SSD_LZB_EN
    // Walk down from the MSD; a digit blanks while everything at or above it is zero.
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        lz_blank = '0;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            all_zero    = all_zero && (active[k] == 4'd0);
            lz_blank[k] = all_zero;
        end
    end
`else
    assign lz_blank = '0;
`endif

    assign seg_next = lz_blank[idx] ? SEG_BLANK : cur_seg;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt    <= '0;
            idx        <= '0;
            active     <= '0;
            pending    <= '0;
            pend_flag  <= 1'b0;
            an         <= '1;
            C          <= SEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick)
                idx <= wrap ? '0 : idx + 1'b1;

            // A load coinciding with the boundary bypasses the pending buffer.
            if (wrap) begin
                if (load)
                    active <= digits;
                else if (pend_flag)
                    active <= pending;
                pend_flag <= 1'b0;
            end else if (load) begin
                pending   <= digits;
                pend_flag <= 1'b1;
            end

            an <= ~(NUM_DIGITS'(1) << idx);
            C  <= seg_next;
            // Raised one cycle early so the pulse occupies the boundary cycle itself.
            frame_done <= (div_cnt == DW'(REFRESH_DIV - 2)) && (idx == IW'(NUM_DIGITS - 1));
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed self-checking bench for ssd_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=4.
// Expectations follow SSD_LZB_EN when the bench is built with it defined.
module tb_ssd_scan_ctrl;

    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S7 = 7'b0001111;
    localparam logic [6:0] S9 = 7'b0000100;
    localparam logic [6:0] SB = 7'b1111111;
`ifdef SSD_LZB_EN
    localparam logic [6:0] SZ = SB;   // zero in a leading position
`else
    localparam logic [6:0] SZ = S0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] digits = 16'h0000;
    logic [3:0]  an;
    logic [6:0]  C;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    ssd_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .digits     (digits),
        .an         (an),
        .C          (C),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic wait_fd();
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        if (frame_done !== 1'b1) begin
            checks++; errors++;
            $display("FAIL wait_frame_done: frame_done=%b after %0d cycles, required 1", frame_done, n);
        end
    endtask

    // Call right after the boundary edge; samples each digit slot's first cycle.
    task automatic read_frame(input string name, input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3);
        logic [6:0] exp_c [4];
        exp_c[0] = e0; exp_c[1] = e1; exp_c[2] = e2; exp_c[3] = e3;
        for (int j = 1; j <= 13; j++) begin
            @(posedge clk); #1;
            if ((j - 1) % 4 == 0) begin
                int d;
                logic [3:0] exp_an;
                d = (j - 1) / 4;
                exp_an = ~(4'b0001 << d);
                checks++;
                if (an !== exp_an) begin
                    errors++;
                    $display("FAIL %s_an%0d: an=%b required %b", name, d, an, exp_an);
                end
                checks++;
                if (C !== exp_c[d]) begin
                    errors++;
                    $display("FAIL %s_seg%0d: C=%b required %b", name, d, C, exp_c[d]);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (an !== 4'b1111 || C !== SB || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: an=%b C=%b fd=%b required 1111 1111111 0", an, C, frame_done);
            end
        end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_scan_walk();
        int pulses;
        logic [3:0] exp_an;
        pulses = 0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            exp_an = ~(4'b0001 << (k / 4));
            checks++;
            if (an !== exp_an) begin
                errors++;
                $display("FAIL walk_an k=%0d: an=%b required %b", k, an, exp_an);
            end
            checks++;
            if (frame_done !== (k == 14)) begin
                errors++;
                $display("FAIL walk_fd k=%0d: frame_done=%b required %b", k, frame_done, (k == 14));
            end
            if (frame_done === 1'b1) pulses++;
            if (k == 0) begin
                checks++;
                if (C !== S0) begin
                    errors++;
                    $display("FAIL walk_first_seg: C=%b required %b", C, S0);
                end
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL walk_fd_count: pulses=%0d required 1", pulses);
        end
    endtask

    task automatic test_load_deferred();
        logic [6:0] exp_c;
        @(negedge clk); load = 1'b1; digits = 16'h1234;
        @(negedge clk); load = 1'b0;
        for (int n = 0; n < 40 && frame_done !== 1'b1; n++) begin
            @(posedge clk); #1;
            exp_c = (an == 4'b1110) ? S0 : SZ;
            checks++;
            if (C !== exp_c) begin
                errors++;
                $display("FAIL deferred_old_seg: an=%b C=%b required %b", an, C, exp_c);
            end
        end
        wait_fd();
        @(posedge clk);
        read_frame("load_1234", S4, S3, S2, S1);
    endtask

    task automatic test_overwrite_pending();
        @(negedge clk); load = 1'b1; digits = 16'h5678;
        @(negedge clk); digits = 16'h0009;
        @(negedge clk); load = 1'b0;
        wait_fd();
        @(posedge clk);
        read_frame("overwrite", S9, SZ, SZ, SZ);
    endtask

    task automatic test_load_on_boundary();
        @(negedge clk); load = 1'b1; digits = 16'h7777;
        @(negedge clk); load = 1'b0;
        wait_fd();
        load = 1'b1; digits = 16'h4321;
        @(posedge clk); #1;
        load = 1'b0;
        read_frame("boundary_load", S1, S2, S3, S4);
        wait_fd();
        @(posedge clk);
        read_frame("boundary_hold", S1, S2, S3, S4);
    endtask

    task automatic test_blank_codes();
        @(negedge clk); load = 1'b1; digits = 16'h00AF;
        @(negedge clk); load = 1'b0;
        wait_fd();
        @(posedge clk);
        read_frame("blank_00af", SB, SB, SZ, SZ);
    endtask

    task automatic test_reset_mid_frame();
        wait_fd();
        @(posedge clk);
        repeat (8) @(posedge clk);
        @(negedge clk); load = 1'b1; digits = 16'h8888;
        @(negedge clk); load = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (an !== 4'b1111 || C !== SB || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: an=%b C=%b fd=%b required 1111 1111111 0", an, C, frame_done);
        end
        @(negedge clk); reset = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                checks++;
                if (an !== 4'b1110 || C !== S0) begin
                    errors++;
                    $display("FAIL midreset_restart: an=%b C=%b required 1110 %b", an, C, S0);
                end
            end
            checks++;
            if (frame_done !== (k == 14)) begin
                errors++;
                $display("FAIL midreset_fd k=%0d: frame_done=%b required %b", k, frame_done, (k == 14));
            end
        end
        @(posedge clk);
        read_frame("midreset_cleared", S0, SZ, SZ, SZ);
    endtask

    initial begin
        test_reset();
        test_scan_walk();
        test_load_deferred();
        test_overwrite_pending();
        test_load_on_boundary();
        test_blank_codes();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
